// File: rtl/rv32i_cdb_arbiter_if.sv
// Result-side bus between the execution functional units and the CDB arbiter.
// Handshake: a transfer happens on a cycle where vld and rdy are both high at
// the rising edge of clk; a producer holding vld may not depend on rdy to
// raise it, and rdy never depends combinationally on the consumer's own rdy.
// The master modport is the environment side (FUs + CDB consumer), the slave
// modport is the arbiter.
interface rv32i_cdb_arbiter_if #(
  parameter int NUM_FU               = 4,
  parameter int DATA_W               = 32,
  parameter int PHYS_REG_FILE_IDX_BW = 6,
  parameter int ROB_DEPTH            = 32
);
  localparam int ROB_W = $clog2(ROB_DEPTH);

  logic                                 i_flush;
  logic [NUM_FU-1:0]                    i_fu_vld;
  logic [NUM_FU-1:0][DATA_W-1:0]        i_fu_data;
  logic [NUM_FU-1:0][PHYS_REG_FILE_IDX_BW-1:0] i_fu_tag;
  logic [NUM_FU-1:0][ROB_W-1:0]         i_fu_rob_idx;
  logic [NUM_FU-1:0]                    i_fu_flag;
  logic [NUM_FU-1:0]                    o_fu_rdy;
  logic                                 i_cdb_rdy;
  logic                                 o_cdb_vld;
  logic [DATA_W-1:0]                    o_cdb_data;
  logic [PHYS_REG_FILE_IDX_BW-1:0]      o_cdb_tag;
  logic [ROB_W-1:0]                     o_cdb_rob_idx;
  logic                                 o_cdb_flag;

  modport master (
    output i_flush, i_fu_vld, i_fu_data, i_fu_tag, i_fu_rob_idx, i_fu_flag, i_cdb_rdy,
    input  o_fu_rdy, o_cdb_vld, o_cdb_data, o_cdb_tag, o_cdb_rob_idx, o_cdb_flag
  );

  modport slave (
    input  i_flush, i_fu_vld, i_fu_data, i_fu_tag, i_fu_rob_idx, i_fu_flag, i_cdb_rdy,
    output o_fu_rdy, o_cdb_vld, o_cdb_data, o_cdb_tag, o_cdb_rob_idx, o_cdb_flag
  );
endinterface

// File: rtl/rv32i_cdb_arbiter.sv
// Round-robin collector of functional-unit results onto the common data bus.
// One winner per cycle is registered into a single-entry CDB output register;
// the round-robin pointer moves past the winner only on an actual handshake.
// dbg_rr_ptr exposes the round-robin pointer for observation.
module rv32i_cdb_arbiter #(
  parameter int NUM_FU               = 4,
  parameter int DATA_W               = 32,
  parameter int PHYS_REG_FILE_IDX_BW = 6,
  parameter int ROB_DEPTH            = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  rv32i_cdb_arbiter_if.slave        bus,
  output logic [$clog2(NUM_FU)-1:0] dbg_rr_ptr
);
  localparam int PTR_W = $clog2(NUM_FU);
  localparam int ROB_W = $clog2(ROB_DEPTH);

  logic [PTR_W-1:0]                rr_ptr;
  logic [PTR_W-1:0]                grant_idx;
  logic [PTR_W-1:0]                scan;
  logic [PTR_W-1:0]                next_ptr;
  logic [NUM_FU-1:0]               grant;
  logic                            found;
  logic                            accept;
  logic                            open;
  logic                            handshake;

  logic                            cdb_vld;
  logic [DATA_W-1:0]               cdb_data;
  logic [PHYS_REG_FILE_IDX_BW-1:0] cdb_tag;
  logic [ROB_W-1:0]                cdb_rob_idx;
  logic                            cdb_flag;

  // Round-robin search: first valid FU at or after rr_ptr, wrapping modulo NUM_FU.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan      = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      scan = PTR_W'((int'(rr_ptr) + i) % NUM_FU);
      if (!found && bus.i_fu_vld[scan]) begin
        found        = 1'b1;
        grant[scan]  = 1'b1;
        grant_idx    = scan;
      end
    end
  end

  // The output register can take a new result when empty or draining; flush and reset block it.
  assign accept    = ~cdb_vld | bus.i_cdb_rdy;
  assign open      = accept & ~bus.i_flush & rstn;
  assign handshake = found & open;
  assign next_ptr  = (grant_idx == PTR_W'(NUM_FU - 1)) ? '0 : grant_idx + PTR_W'(1);

  assign bus.o_fu_rdy      = grant & {NUM_FU{open}};
  assign bus.o_cdb_vld     = cdb_vld;
  assign bus.o_cdb_data    = cdb_data;
  assign bus.o_cdb_tag     = cdb_tag;
  assign bus.o_cdb_rob_idx = cdb_rob_idx;
  assign bus.o_cdb_flag    = cdb_flag;
  assign dbg_rr_ptr        = rr_ptr;

  // CDB output register and round-robin pointer; flush beats both load and drain.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cdb_vld     <= 1'b0;
      cdb_data    <= '0;
      cdb_tag     <= '0;
      cdb_rob_idx <= '0;
      cdb_flag    <= 1'b0;
      rr_ptr      <= '0;
    end else if (bus.i_flush) begin
      cdb_vld <= 1'b0;
    end else if (handshake) begin
      cdb_vld     <= 1'b1;
      cdb_data    <= bus.i_fu_data[grant_idx];
      cdb_tag     <= bus.i_fu_tag[grant_idx];
      cdb_rob_idx <= bus.i_fu_rob_idx[grant_idx];
      cdb_flag    <= bus.i_fu_flag[grant_idx];
      rr_ptr      <= next_ptr;
    end else if (cdb_vld && bus.i_cdb_rdy) begin
      cdb_vld <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rv32i_cdb_arbiter.sv
// Bench for the CDB arbiter: directed vector table, reset-mid-transfer sequence,
// then randomized traffic against a reference model and result scoreboard.
module tb_rv32i_cdb_arbiter;
  localparam int NUM_FU    = 4;
  localparam int DATA_W    = 32;
  localparam int TAG_W     = 6;
  localparam int ROB_DEPTH = 32;
  localparam int ROB_W     = 5;
  localparam int PTR_W     = 2;
  localparam int PAY_W     = DATA_W + TAG_W + ROB_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  rv32i_cdb_arbiter_if #(
    .NUM_FU(NUM_FU), .DATA_W(DATA_W),
    .PHYS_REG_FILE_IDX_BW(TAG_W), .ROB_DEPTH(ROB_DEPTH)
  ) bus ();

  logic [PTR_W-1:0] dbg_rr_ptr;

  rv32i_cdb_arbiter #(
    .NUM_FU(NUM_FU), .DATA_W(DATA_W),
    .PHYS_REG_FILE_IDX_BW(TAG_W), .ROB_DEPTH(ROB_DEPTH)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .dbg_rr_ptr(dbg_rr_ptr)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  logic [PAY_W-1:0] exp_q[$];
  int accepted  = 0;
  int delivered = 0;
  int dropped   = 0;

  // Reference model state: what the CDB register should hold and where the scan starts.
  int               model_ptr = 0;
  logic             model_vld = 1'b0;
  logic [PAY_W-1:0] model_pay = '0;

  logic [DATA_W-1:0] fd[NUM_FU];
  logic [TAG_W-1:0]  ft[NUM_FU];
  logic [ROB_W-1:0]  fr[NUM_FU];
  logic              ff[NUM_FU];

  typedef struct {
    logic [NUM_FU-1:0] vld;
    logic              crdy;
    logic              fl;
    logic [NUM_FU-1:0] exp_rdy;
    logic              exp_cvld;
    int                exp_ptr;
    int                exp_fu;   // FU whose fixed payload sits on the CDB, -1 if none checked
  } vec_t;

  vec_t tbl[24];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PAY_W-1:0] cdb_pay();
    return {bus.o_cdb_data, bus.o_cdb_tag, bus.o_cdb_rob_idx, bus.o_cdb_flag};
  endfunction

  function automatic logic [PAY_W-1:0] fu_pay(input int k);
    return {fd[k], ft[k], fr[k], ff[k]};
  endfunction

  // Winner = valid FU with the smallest circular distance from the pointer.
  function automatic int pick(input logic [NUM_FU-1:0] v, input int p);
    int best;
    int w;
    int d;
    best = NUM_FU;
    w    = -1;
    for (int k = 0; k < NUM_FU; k++) begin
      if (v[k]) begin
        d = (k - p + NUM_FU) % NUM_FU;
        if (d < best) begin
          best = d;
          w    = k;
        end
      end
    end
    return w;
  endfunction

  function automatic vec_t mk(input logic [NUM_FU-1:0] vld, input logic crdy, input logic fl,
                              input logic [NUM_FU-1:0] rdy, input logic cvld, input int ptr,
                              input int fu);
    vec_t v;
    v.vld = vld; v.crdy = crdy; v.fl = fl;
    v.exp_rdy = rdy; v.exp_cvld = cvld; v.exp_ptr = ptr; v.exp_fu = fu;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply(input logic rst_n, input logic [NUM_FU-1:0] vld, input logic crdy,
                       input logic fl, input logic rnd);
    @(negedge clk);
    rstn = rst_n;
    for (int k = 0; k < NUM_FU; k++) begin
      if (rnd) begin
        fd[k] = $urandom;
        ft[k] = TAG_W'($urandom);
        fr[k] = ROB_W'($urandom);
        ff[k] = 1'($urandom);
      end else begin
        fd[k] = DATA_W'(5 + k);
        ft[k] = TAG_W'(3 + k);
        fr[k] = ROB_W'(7 + k);
        ff[k] = 1'(k % 2);
      end
      bus.i_fu_data[PTR_W'(k)]    = fd[k];
      bus.i_fu_tag[PTR_W'(k)]     = ft[k];
      bus.i_fu_rob_idx[PTR_W'(k)] = fr[k];
      bus.i_fu_flag[PTR_W'(k)]    = ff[k];
    end
    bus.i_fu_vld  = vld;
    bus.i_cdb_rdy = crdy;
    bus.i_flush   = fl;
    #1;
  endtask

  // Compare the DUT with the model for this cycle, run the scoreboard, advance the model.
  task automatic model_step();
    int               win;
    logic             acc;
    logic [NUM_FU-1:0] exp_rdy;
    logic [PAY_W-1:0] front;
    win     = pick(bus.i_fu_vld, model_ptr);
    acc     = !model_vld || bus.i_cdb_rdy;
    exp_rdy = (rstn && !bus.i_flush && acc && win >= 0) ? (NUM_FU'(1) << win) : '0;

    chk("fu_rdy",  64'(bus.o_fu_rdy),  64'(exp_rdy));
    chk("cdb_vld", 64'(bus.o_cdb_vld), 64'(model_vld));
    chk("cdb_pay", 64'(cdb_pay()),     64'(model_pay));
    chk("rr_ptr",  64'(dbg_rr_ptr),    64'(model_ptr));

    if (rstn && !bus.i_flush && bus.o_cdb_vld && bus.i_cdb_rdy) begin
      chk("sb_nonempty", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        front = exp_q.pop_front();
        chk("sb_order", 64'(cdb_pay()), 64'(front));
        delivered++;
      end
    end else if ((!rstn || bus.i_flush) && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      dropped++;
    end

    if (!rstn) begin
      model_vld = 1'b0;
      model_pay = '0;
      model_ptr = 0;
    end else if (bus.i_flush) begin
      model_vld = 1'b0;
    end else if (exp_rdy != '0) begin
      model_pay = fu_pay(win);
      model_vld = 1'b1;
      model_ptr = (win + 1) % NUM_FU;
      exp_q.push_back(model_pay);
      accepted++;
    end else if (model_vld && bus.i_cdb_rdy) begin
      model_vld = 1'b0;
    end
    @(posedge clk);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    tbl[0]  = mk(4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, 0, -1);
    tbl[1]  = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1,  0);
    tbl[2]  = mk(4'b1111, 1'b1, 1'b0, 4'b0010, 1'b0, 1, -1);
    tbl[3]  = mk(4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2,  1);
    tbl[4]  = mk(4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 3,  2);
    tbl[5]  = mk(4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 0,  3);
    tbl[6]  = mk(4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 1,  0);
    tbl[7]  = mk(4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2,  1);
    tbl[8]  = mk(4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 3,  2);
    tbl[9]  = mk(4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 0,  3);
    tbl[10] = mk(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 1,  0);
    tbl[11] = mk(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 1,  0);
    tbl[12] = mk(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 1,  0);
    tbl[13] = mk(4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 1,  0);
    tbl[14] = mk(4'b0100, 1'b1, 1'b1, 4'b0000, 1'b1, 2,  1);
    tbl[15] = mk(4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, 2, -1);
    tbl[16] = mk(4'b1010, 1'b1, 1'b0, 4'b1000, 1'b1, 3,  2);
    tbl[17] = mk(4'b1010, 1'b1, 1'b0, 4'b0010, 1'b1, 0,  3);
    tbl[18] = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2,  1);
    tbl[19] = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2, -1);
    tbl[20] = mk(4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 2, -1);
    tbl[21] = mk(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 1,  0);
    tbl[22] = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1,  0);
    tbl[23] = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1, -1);

    // First reset cycle: DUT state is still unknown, so nothing is compared.
    apply(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    // Second reset cycle: outputs cleared, no rdy pulse while rstn is low.
    apply(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
    chk("reset_rdy", 64'(bus.o_fu_rdy), 64'(0));
    chk("reset_vld", 64'(bus.o_cdb_vld), 64'(0));
    model_step();

    // Directed vector table.
    for (int i = 0; i < 24; i++) begin
      apply(1'b1, tbl[i].vld, tbl[i].crdy, tbl[i].fl, 1'b0);
      chk($sformatf("t%0d_rdy", i), 64'(bus.o_fu_rdy), 64'(tbl[i].exp_rdy));
      chk($sformatf("t%0d_cvld", i), 64'(bus.o_cdb_vld), 64'(tbl[i].exp_cvld));
      chk($sformatf("t%0d_ptr", i), 64'(dbg_rr_ptr), 64'(tbl[i].exp_ptr));
      if (tbl[i].exp_fu >= 0) begin
        chk($sformatf("t%0d_data", i), 64'(bus.o_cdb_data), 64'(5 + tbl[i].exp_fu));
        chk($sformatf("t%0d_tag", i), 64'(bus.o_cdb_tag), 64'(3 + tbl[i].exp_fu));
        chk($sformatf("t%0d_rob", i), 64'(bus.o_cdb_rob_idx), 64'(7 + tbl[i].exp_fu));
      end
      model_step();
    end

    // Reset while a broadcast is pending: it is dropped and the pointer returns to 0.
    apply(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
    model_step();
    apply(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
    chk("rst_mid_rdy", 64'(bus.o_fu_rdy), 64'(0));
    chk("rst_mid_pending", 64'(bus.o_cdb_vld), 64'(1));
    model_step();
    apply(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
    chk("rst_mid_vld", 64'(bus.o_cdb_vld), 64'(0));
    chk("rst_mid_ptr", 64'(dbg_rr_ptr), 64'(0));
    chk("rst_mid_data", 64'(bus.o_cdb_data), 64'(0));
    model_step();

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      apply(($urandom_range(0, 99) != 0),
            NUM_FU'($urandom),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0),
            1'b1);
      model_step();
    end

    // Drain anything still in the CDB register.
    for (int n = 0; n < 4; n++) begin
      apply(1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);
      model_step();
    end
    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    chk("sb_balance", 64'(accepted), 64'(delivered + dropped));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
